// File: rtl/dp_share_scheduler.sv
// dp_share_scheduler
// Round-robin scheduler that time-shares one combinational transform datapath
// among NUM_REQ requesters. One operand is accepted per transaction, held on
// dp_in for DP_LAT cycles, and the sampled dp_out is returned with the
// requester index over a backpressured response channel.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot-or-zero)
//   req_data          packed operands, requester i owns [i*IN_W +: IN_W]
//   dp_in / dp_out    registered operand to / result from the shared datapath
//   rsp_valid/ready   response handshake
//   rsp_data, rsp_id  captured result and originating requester
//   busy              any state other than IDLE
//   done_count        saturating count of completed responses
//
// state | meaning
// IDLE  | no transaction in flight
// WAIT  | operand on dp_in, settle counter running
// RESP  | rsp_valid high, waiting for the consumer
module dp_share_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 3,
  parameter int OUT_W   = 20,
  parameter int ID_W    = 2,
  parameter int DP_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         dp_in,
  input  logic [OUT_W-1:0]        dp_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_count
);

  localparam int WC_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_reg;
  logic [WC_W-1:0]  wait_cnt;

  logic             grant_ok;
  logic             found;
  logic             accept;
  logic [ID_W-1:0]  gnt_idx;
  logic [IN_W-1:0]  gnt_data;
  int               cand;

  // Search starts one past the last winner so the previous grantee has the
  // lowest priority this round.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && cand == i && req_valid[i]) begin
          found    = 1'b1;
          gnt_idx  = ID_W'(i);
          gnt_data = req_data[i*IN_W +: IN_W];
        end
      end
    end
  end

  // Granting in RESP is only safe when the pending response drains this cycle.
  assign grant_ok = !rst && (state == IDLE || (state == RESP && rsp_ready));
  assign accept   = grant_ok && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (gnt_idx == ID_W'(i));
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      id_reg     <= '0;
      wait_cnt   <= '0;
      dp_in      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dp_in    <= gnt_data;
            id_reg   <= gnt_idx;
            rr_ptr   <= gnt_idx;
            wait_cnt <= WC_W'(DP_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            rsp_data  <= dp_out;
            rsp_id    <= id_reg;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (done_count != '1) done_count <= done_count + 1'b1;
            if (accept) begin
              dp_in    <= gnt_data;
              id_reg   <= gnt_idx;
              rr_ptr   <= gnt_idx;
              wait_cnt <= WC_W'(DP_LAT - 1);
              state    <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_share_scheduler.sv
module tb_dp_share_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic [3:0]  req_valid, req_ready;
  logic [11:0] req_data;
  logic [2:0]  dp_in;
  logic [19:0] dp_out, rsp_data;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [15:0] done_count;

  // DP_LAT=3 instance
  logic [3:0]  l_req_valid, l_req_ready;
  logic [11:0] l_req_data;
  logic [2:0]  l_dp_in;
  logic [19:0] l_dp_out, l_rsp_data;
  logic        l_rsp_valid, l_rsp_ready, l_busy;
  logic [1:0]  l_rsp_id;
  logic [15:0] l_done_count;

  // CNT_W=4 instance
  logic [3:0]  s_req_valid, s_req_ready;
  logic [11:0] s_req_data;
  logic [2:0]  s_dp_in;
  logic [19:0] s_dp_out, s_rsp_data;
  logic        s_rsp_valid, s_rsp_ready, s_busy;
  logic [1:0]  s_rsp_id;
  logic [3:0]  s_done_count;

  assign dp_out   = {17'd0, dp_in}   * 20'd5 + 20'd100;
  assign l_dp_out = {17'd0, l_dp_in} * 20'd5 + 20'd100;
  assign s_dp_out = {17'd0, s_dp_in} * 20'd5 + 20'd100;

  dp_share_scheduler u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .done_count(done_count)
  );

  dp_share_scheduler #(.DP_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(l_req_valid), .req_data(l_req_data),
    .req_ready(l_req_ready), .dp_in(l_dp_in), .dp_out(l_dp_out),
    .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_data(l_rsp_data),
    .rsp_id(l_rsp_id), .busy(l_busy), .done_count(l_done_count)
  );

  dp_share_scheduler #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_data(s_req_data),
    .req_ready(s_req_ready), .dp_in(s_dp_in), .dp_out(s_dp_out),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_id(s_rsp_id), .busy(s_busy), .done_count(s_done_count)
  );

  int passed = 0;
  int total  = 0;
  logic [21:0] sb[$];   // {id, data}

  function automatic logic [19:0] model(input logic [2:0] x);
    return 20'(x) * 20'd5 + 20'd100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Response scoreboard for the main instance: a handshake seen at the
  // falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      logic [21:0] e;
      total++;
      assert (sb.size() > 0) passed++;
      else $error("FAIL rsp_unexpected: observed id %0d data %0d expected no response", rsp_id, rsp_data);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_rsp_id",   32'(rsp_id),   32'(e[21:20]));
        chk("sb_rsp_data", 32'(rsp_data), 32'(e[19:0]));
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    req_valid = 4'b1111; req_data = '0; rsp_ready = 1'b1;
    l_req_valid = '0; l_req_data = '0; l_rsp_ready = 1'b1;
    s_req_valid = '0; s_req_data = '0; s_rsp_ready = 1'b1;
    tick(2);
    #1;
    chk("rst_req_ready",  32'(req_ready),  0);
    chk("rst_rsp_valid",  32'(rsp_valid),  0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_dp_in",      32'(dp_in),      0);
    chk("rst_rsp_data",   32'(rsp_data),   0);
    chk("rst_rsp_id",     32'(rsp_id),     0);
    chk("rst_done_count", 32'(done_count), 0);

    // round robin, all requesters valid, operands 1..4
    tick;
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      #1;
      chk("rr_grant", 32'(req_ready), 1 << g);
      sb.push_back({2'(g), model(3'(g + 1))});
      tick;
      chk("rr_wait_dp_in", 32'(dp_in), g + 1);
      chk("rr_wait_ready", 32'(req_ready), 0);
      if (n == 4) req_valid = '0;
      tick;
    end
    tick;
    chk("rr_done_count", 32'(done_count), 5);
    chk("rr_idle_busy",  32'(busy), 0);

    // single request from requester 2, operand 6
    req_valid = 4'b0100;
    req_data[8:6] = 3'd6;
    #1;
    chk("single_grant", 32'(req_ready), 32'b0100);
    sb.push_back({2'd2, model(3'd6)});
    tick;
    req_valid = '0;
    chk("single_busy",      32'(busy),      1);
    chk("single_dp_in",     32'(dp_in),     6);
    chk("single_no_rsp_c1", 32'(rsp_valid), 0);
    tick;
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_data",  32'(rsp_data),  130);
    chk("single_rsp_id",    32'(rsp_id),    2);
    tick;
    chk("single_done_count", 32'(done_count), 6);
    chk("single_data_held",  32'(rsp_data),   130);
    chk("single_idle",       32'(busy),       0);

    // backpressure: requester 3 first, then requester 1 waits behind it
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_data[11:9] = 3'd5;
    #1;
    chk("bp_grant3", 32'(req_ready), 32'b1000);
    sb.push_back({2'd3, model(3'd5)});
    tick;
    req_valid = '0;
    tick;
    req_valid = 4'b0010;
    req_data[5:3] = 3'd3;
    repeat (5) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data",  32'(rsp_data),  125);
      chk("bp_rsp_id",    32'(rsp_id),    3);
      chk("bp_no_grant",  32'(req_ready), 0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_same_cycle_grant", 32'(req_ready), 32'b0010);
    sb.push_back({2'd1, model(3'd3)});
    tick;
    chk("bp_busy_kept", 32'(busy),       1);
    chk("bp_rsp_drop",  32'(rsp_valid),  0);
    chk("bp_dp_in",     32'(dp_in),      3);
    chk("bp_count",     32'(done_count), 7);
    req_valid = '0;
    tick;
    chk("bp2_rsp_id", 32'(rsp_id), 1);
    tick;
    chk("bp2_count", 32'(done_count), 8);

    // reset in the middle of WAIT discards the transaction
    req_valid = 4'b0001;
    req_data[2:0] = 3'd2;
    #1;
    chk("rstw_grant0", 32'(req_ready), 32'b0001);
    tick;
    req_valid = 4'b1111;
    chk("rstw_in_wait", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rstw_rsp_valid", 32'(rsp_valid),  0);
    chk("rstw_busy",      32'(busy),       0);
    chk("rstw_dp_in",     32'(dp_in),      0);
    chk("rstw_count",     32'(done_count), 0);
    chk("rstw_ready",     32'(req_ready),  0);
    tick;
    rst = 1'b0;
    #1;
    chk("rstw_first_grant", 32'(req_ready), 32'b0001);
    sb.push_back({2'd0, model(3'd2)});
    tick;
    req_valid = '0;
    tick;
    tick;
    chk("rstw_count_after", 32'(done_count), 1);
    chk("sb_drained",       sb.size(),       0);

    // DP_LAT=3: operand 7 from requester 0
    l_req_valid = 4'b0001;
    l_req_data[2:0] = 3'd7;
    #1;
    chk("lat3_grant", 32'(l_req_ready), 32'b0001);
    tick;
    l_req_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      chk("lat3_busy",     32'(l_busy),      1);
      chk("lat3_dp_in",    32'(l_dp_in),     7);
      chk("lat3_no_rsp",   32'(l_rsp_valid), 0);
      tick;
    end
    chk("lat3_rsp_valid", 32'(l_rsp_valid), 1);
    chk("lat3_rsp_data",  32'(l_rsp_data),  135);
    chk("lat3_rsp_id",    32'(l_rsp_id),    0);
    tick;
    chk("lat3_count", 32'(l_done_count), 1);
    chk("lat3_idle",  32'(l_busy),       0);

    // CNT_W=4 saturation with continuous traffic
    s_req_valid = 4'b0001;
    s_req_data[2:0] = 3'd1;
    tick(29);
    chk("sat_count14", 32'(s_done_count), 14);
    tick(2);
    chk("sat_count15", 32'(s_done_count), 15);
    tick(4);
    chk("sat_hold",     32'(s_done_count), 15);
    chk("sat_busy",     32'(s_busy),       1);
    chk("sat_rsp_data", 32'(s_rsp_data),   105);
    s_req_valid = '0;
    tick(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dp_share_scheduler.md
Name: dp_share_scheduler

Overview:
- Round-robin scheduler that shares one combinational transform datapath (3-bit operand in, 20-bit result out) among NUM_REQ requesters.
- Accepts one operand per transaction over valid/ready and drives it into the datapath.
- Waits DP_LAT cycles for settle, captures the result, and returns it with the requester ID over a backpressured response channel.
- Sits between the request fabric and the single shared datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 3, operand width fed to the datapath.
- OUT_W, 20, datapath result width.
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.
- DP_LAT, 1, cycles dp_in is held stable before dp_out is sampled (1..4).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_data, input, NUM_REQ*IN_W, packed operands; requester i owns bits [i*IN_W +: IN_W].
- req_ready, output, NUM_REQ, one-hot-or-zero grant/accept.
- dp_in, output, IN_W, operand driven to the shared datapath (registered).
- dp_out, input, OUT_W, datapath result.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumer ready.
- rsp_data, output, OUT_W, captured result.
- rsp_id, output, ID_W, requester index of the response.
- busy, output, 1, high in any state other than IDLE.
- done_count, output, CNT_W, saturating count of completed responses.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; dp_in=0; rsp_valid=0; rsp_data=0; rsp_id=0; done_count=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while rst is high.
- States:
  - IDLE: no transaction in flight.
  - WAIT: operand on dp_in, settle counter running.
  - RESP: rsp_valid high, waiting for the consumer.
- Arbitration:
  - Combinational search starting at rr_ptr+1 (mod NUM_REQ) for the first set req_valid bit.
  - Grant is permitted in IDLE, or in RESP in a cycle where rsp_ready=1.
  - req_ready[g]=1 only for the winner g; all other bits 0.
  - req_ready never asserts in WAIT, or in RESP without rsp_ready.
  - req_ready does not depend on req_data.
- Accept edge (req_valid[g] & req_ready[g]):
  - dp_in <= req_data slice g; id_reg <= g; rr_ptr <= g.
  - wait_cnt <= DP_LAT-1; state -> WAIT.
  - rr_ptr updates only on an accepted grant.
- WAIT:
  - dp_in holds stable.
  - If wait_cnt != 0, decrement.
  - If wait_cnt == 0: rsp_data <= dp_out; rsp_id <= id_reg; rsp_valid <= 1; state -> RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id hold stable until rsp_valid & rsp_ready.
  - On the handshake edge: rsp_valid <= 0; done_count += 1, saturating at all-ones (no wrap).
  - If a grant also occurs that cycle: next state WAIT (back-to-back); otherwise IDLE.
- Latency: accept in cycle 0 -> rsp_valid first high in cycle DP_LAT+1.
- Throughput: with rsp_ready tied high and continuous requests, one accept every DP_LAT+1 cycles.
- dp_in holds its last operand in IDLE and RESP; it changes only on an accept edge.
- rsp_data keeps its last value after the handshake; it is undefined-free (never X after reset).
- A requester dropping req_valid before being granted is simply skipped; no state is kept per requester.
- Async reset mid-WAIT or mid-RESP: the in-flight transaction is discarded, no response is produced, and all state returns to reset values immediately.
- busy = (state != IDLE).

Test Plan:
- Bench datapath stub for all scenarios: dp_out = {17'd0, dp_in} * 20'd5 + 20'd100.
- Single request, DP_LAT=1, rsp_ready=1: req_valid=4'b0100, data2=3'd6 accepted in cycle 0 -> cycle 2: rsp_valid=1, rsp_data=20'd130, rsp_id=2; done_count=1 after the handshake.
- Round robin: all four valid continuously, operands 1,2,3,4, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_data 105,110,115,120; accepts spaced every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles while rsp_valid=1 -> rsp_data/rsp_id stable, req_ready=0 throughout. Then rsp_ready=1 with req1 valid -> same-cycle grant of req1, busy stays 1.
- DP_LAT=3 build: single request, operand 7 -> dp_in=7 stable for 3 WAIT cycles; rsp_valid in cycle 4 with rsp_data=135.
- Reset mid-WAIT: assert rst during WAIT -> rsp_valid=0, busy=0, dp_in=0, done_count=0 immediately. After release, the first grant goes to requester 0.
- Saturation (CNT_W=4 build): 17 completed transactions -> done_count reaches 4'hF and stays there.
